// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination-lock controller.
// Optional feature macro used by the top: COMBO_LOCK_TIMEOUT_EN.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10
  } state_t;

  localparam int DIGIT_W = 2;

  // Width of a down-counter able to hold the largest of the three cycle counts.
  function automatic int timer_width(input int open_cyc, input int lockout_cyc,
                                     input int timeout_cyc);
    int m;
    m = open_cyc;
    if (lockout_cyc > m) m = lockout_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/combo_lock_fsm_timer.sv
// Loadable down-counter shared by the OPEN, LOCKOUT and inter-key timeout paths.
// The count stops at zero; done flags the last cycle of a loaded interval.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/combo_lock_fsm.sv
// Code-lock controller wrapped around an external 2-bit equality comparator.
// The expected digit is driven out on EXP_0/EXP_1 and the comparator result
// comes back on MATCH. Optional inter-key timeout: define COMBO_LOCK_TIMEOUT_EN.
//
// Interface: KEY_VALID is a one-cycle strobe with no backpressure. MATCH is
// only meaningful while KEY_VALID=1; every strobe in ENTRY is evaluated, and
// strobes in OPEN or LOCKOUT are dropped.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int                      CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]   CODE        = 8'b10_01_11_00,
  parameter int                      MAX_FAIL    = 3,
  parameter int                      OPEN_CYC    = 8,
  parameter int                      LOCKOUT_CYC = 16,
  parameter int                      TIMEOUT_CYC = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          KEY_VALID,
  input  logic                          MATCH,
  output logic                          EXP_0,
  output logic                          EXP_1,
  output logic                          UNLOCK,
  output logic                          ALARM,
  output logic [$clog2(MAX_FAIL+1)-1:0] FAIL_CNT,
  output state_t                        dbg_state
);

  localparam int TW     = timer_width(OPEN_CYC, LOCKOUT_CYC, TIMEOUT_CYC);
  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL - 1);

  state_t              state, next_state;
  logic [IDX_W-1:0]    idx, next_idx;
  logic [FAIL_W-1:0]   fail_cnt, next_fail_cnt;
  logic                unlock, alarm;
  logic                timer_load;
  logic [TW-1:0]       timer_val;
  logic                timer_done;
  logic [DIGIT_W-1:0]  exp_digit;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // State, progress and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY;
      idx      <= '0;
      fail_cnt <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= next_state;
      idx      <= next_idx;
      fail_cnt <= next_fail_cnt;
      unlock   <= (next_state == OPEN);
      alarm    <= (next_state == LOCKOUT);
    end
  end

  // Next-state logic: key evaluation in ENTRY, timed exits from OPEN/LOCKOUT.
  always_comb begin
    next_state    = state;
    next_idx      = idx;
    next_fail_cnt = fail_cnt;
    timer_load    = 1'b0;
    timer_val     = '0;
    case (state)
      ENTRY: begin
        if (KEY_VALID) begin
          if (MATCH) begin
            if (idx == LAST_IDX) begin
              next_idx      = '0;
              next_fail_cnt = '0;
              next_state    = OPEN;
              timer_load    = 1'b1;
              timer_val     = TW'(OPEN_CYC);
            end else begin
              next_idx = idx + IDX_W'(1);
`ifdef COMBO_LOCK_TIMEOUT_EN
              timer_load = 1'b1;
              timer_val  = TW'(TIMEOUT_CYC);
`endif
            end
          end else begin
            // A wrong key restarts entry; it is not re-tried as digit 0.
            next_idx = '0;
            if (fail_cnt == FAIL_LIMIT) begin
              next_fail_cnt = '0;
              next_state    = LOCKOUT;
              timer_load    = 1'b1;
              timer_val     = TW'(LOCKOUT_CYC);
            end else begin
              next_fail_cnt = fail_cnt + FAIL_W'(1);
            end
          end
        end
`ifdef COMBO_LOCK_TIMEOUT_EN
        // Abandon a partial entry after a long idle gap; failures are kept.
        else if ((idx != '0) && timer_done) begin
          next_idx = '0;
        end
`endif
      end
      OPEN: begin
        if (timer_done) next_state = ENTRY;
      end
      LOCKOUT: begin
        if (timer_done) next_state = ENTRY;
      end
      default: begin
        next_state = ENTRY;
        next_idx   = '0;
      end
    endcase
  end

  // Expected digit for the comparator: current code digit in ENTRY, else digit 0.
  always_comb begin
    exp_digit = CODE[DIGIT_W-1:0];
    if (state == ENTRY) begin
      for (int k = 0; k < CODE_LEN; k++) begin
        if (idx == IDX_W'(k)) exp_digit = CODE[DIGIT_W*k +: DIGIT_W];
      end
    end
  end

  assign EXP_0     = exp_digit[1];
  assign EXP_1     = exp_digit[0];
  assign UNLOCK    = unlock;
  assign ALARM     = alarm;
  assign FAIL_CNT  = fail_cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm with an inline equality comparator and a
// cycle-level behavioural model of the lock.
module tb_combo_lock_fsm;
  import combo_lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_a = 2'b00;
  logic       match;
  logic       exp_0, exp_1;
  logic       unlock, alarm;
  logic [1:0] fail_cnt;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  // Code digits 0..3 of 8'b10_01_11_00.
  int code_d[4] = '{0, 3, 1, 2};

  // Model state: remaining open/alarm cycles, entry position, failures, idle run.
  int m_open  = 0;
  int m_alarm = 0;
  int m_pos   = 0;
  int m_fails = 0;
  int m_idle  = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  // Equality comparator: A from the keypad, B from the lock's expected digit.
  assign match = (key_a == {exp_0, exp_1});

  combo_lock_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .KEY_VALID (key_valid),
    .MATCH     (match),
    .EXP_0     (exp_0),
    .EXP_1     (exp_1),
    .UNLOCK    (unlock),
    .ALARM     (alarm),
    .FAIL_CNT  (fail_cnt),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the lock should show after each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_alarm = 0; m_pos = 0; m_fails = 0; m_idle = 0;
    end else if (m_open > 0) begin
      m_open--;
    end else if (m_alarm > 0) begin
      m_alarm--;
    end else if (key_valid) begin
      m_idle = 0;
      if (int'(key_a) == code_d[m_pos]) begin
        if (m_pos == 3) begin
          m_pos = 0; m_fails = 0; m_open = 8;
        end else begin
          m_pos++;
        end
      end else begin
        m_pos = 0;
        m_fails++;
        if (m_fails == 3) begin
          m_fails = 0; m_alarm = 16;
        end
      end
    end else begin
      m_idle++;
`ifdef COMBO_LOCK_TIMEOUT_EN
      if (m_pos > 0 && m_idle >= 32) m_pos = 0;
`endif
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_digit;
    exp_digit = (m_open > 0 || m_alarm > 0) ? 8'd0 : 8'(code_d[m_pos]);
    check("unlock",   8'(unlock),          8'(m_open > 0));
    check("alarm",    8'(alarm),           8'(m_alarm > 0));
    check("fail_cnt", 8'(fail_cnt),        8'(m_fails));
    check("exp",      8'({exp_0, exp_1}),  exp_digit);
  end

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic press(input logic [1:0] d);
    key_valid = 1'b1;
    key_a     = d;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_code();
    press(2'b00); press(2'b11); press(2'b01); press(2'b10);
  endtask

  initial begin
    // Reset held for 3 cycles.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_unlock", 8'(unlock), 8'd0);
    check("rst_alarm",  8'(alarm),  8'd0);
    check("rst_fail",   8'(fail_cnt), 8'd0);
    check("rst_exp",    8'({exp_0, exp_1}), 8'd0);
    rst_n = 1'b1;
    idle(1);

    // Correct entry, back-to-back keys.
    press_code();
    check("open_first", 8'(unlock), 8'd1);
    idle(7);
    check("open_last",  8'(unlock), 8'd1);
    idle(1);
    check("open_end",   8'(unlock), 8'd0);
    check("open_exp",   8'({exp_0, exp_1}), 8'd0);

    // Wrong second digit, then a full correct code.
    press(2'b00); press(2'b10);
    check("wrong_fail", 8'(fail_cnt), 8'd1);
    check("wrong_exp",  8'({exp_0, exp_1}), 8'd0);
    check("wrong_lock", 8'(unlock), 8'd0);
    press_code();
    check("retry_open", 8'(unlock), 8'd1);
    check("retry_fail", 8'(fail_cnt), 8'd0);
    idle(8);

    // Lockout after three failures; keys ignored while locked out.
    press(2'b01); press(2'b01); press(2'b01);
    check("lk_alarm", 8'(alarm), 8'd1);
    check("lk_fail",  8'(fail_cnt), 8'd0);
    press_code();
    check("lk_nounlock", 8'(unlock), 8'd0);
    check("lk_exp",      8'({exp_0, exp_1}), 8'd0);
    idle(12);
    check("lk_end",   8'(alarm), 8'd0);
    check("lk_fail2", 8'(fail_cnt), 8'd0);
    press(2'b00);
    check("lk_after_exp", 8'({exp_0, exp_1}), 8'd3);
    press(2'b01);

    // Async reset in the third OPEN cycle, between clock edges.
    press_code();
    idle(2);
    check("ar_open", 8'(unlock), 8'd1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_unlock", 8'(unlock), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("ar_state", 8'(dbg_state), 8'(ENTRY));

    // Partial entry followed by a long idle gap.
    idle(1);
    press(2'b00); press(2'b11);
    check("to_partial", 8'({exp_0, exp_1}), 8'd1);
    idle(32);
`ifdef COMBO_LOCK_TIMEOUT_EN
    check("to_exp", 8'({exp_0, exp_1}), 8'd0);
`else
    check("to_exp", 8'({exp_0, exp_1}), 8'd1);
`endif
    check("to_fail", 8'(fail_cnt), 8'd0);

    // Randomized keys, mostly correct digits, with occasional long gaps.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        idle($urandom_range(30, 40));
      end else if (r < 60) begin
        if ($urandom_range(0, 9) < 8) press(2'(code_d[m_pos]));
        else press(2'($urandom_range(0, 3)));
      end else begin
        idle(1);
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/combo_lock_fsm.md
Name: combo_lock_fsm

Overview:
Sequential code-lock controller that wraps the 2-bit equality comparator.
- Feeds the comparator: drives the expected code digit onto the comparator's B inputs.
- Consumes the comparator: samples its OUT as MATCH whenever a key is strobed.
- Tracks entry progress, opens the lock after a full correct sequence, and enforces a lockout after repeated failures.
- Sits between the keypad/debounce stage and the actuator/indicator outputs.

Parameters:
- CODE_LEN, 4: number of 2-bit digits in the code; must be >= 1.
- CODE, 8'b10_01_11_00: packed code; digit k = CODE[2k+1:2k], digit 0 in the LSBs; width 2*CODE_LEN.
- MAX_FAIL, 3: consecutive failed entries that trigger lockout; must be >= 1.
- OPEN_CYC, 8: cycles UNLOCK stays high; must be >= 1.
- LOCKOUT_CYC, 16: cycles ALARM stays high; must be >= 1.
- TIMEOUT_CYC, 32: inter-key timeout in cycles; used only with the optional feature.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- KEY_VALID, input, 1: one-cycle strobe, a digit is presented on the comparator A inputs.
- MATCH, input, 1: comparator OUT; sampled only when KEY_VALID=1.
- EXP_0, output, 1: expected digit MSB, wired to comparator B_0.
- EXP_1, output, 1: expected digit LSB, wired to comparator B_1.
- UNLOCK, output, 1: lock open (registered).
- ALARM, output, 1: lockout active (registered).
- FAIL_CNT, output, $clog2(MAX_FAIL+1): consecutive failures so far.

Behaviour:
- States (Moore): ENTRY, OPEN, LOCKOUT.
- Reset (async, rst_n=0): state=ENTRY, idx=0, fail_cnt=0, timer=0, UNLOCK=0, ALARM=0. EXP_0/EXP_1 are combinational from idx, so they show digit 0 during reset.
- EXP = CODE digit[idx] in ENTRY; digit 0 in OPEN and LOCKOUT.
- ENTRY, KEY_VALID=1, MATCH=1, idx<CODE_LEN-1: idx++.
- ENTRY, KEY_VALID=1, MATCH=1, idx=CODE_LEN-1: idx=0, fail_cnt=0, go to OPEN, timer=OPEN_CYC. UNLOCK rises on the next clock edge, i.e. one cycle after the final key.
- ENTRY, KEY_VALID=1, MATCH=0:
  - idx=0 and fail_cnt++.
  - If fail_cnt was MAX_FAIL-1: fail_cnt=0, go to LOCKOUT, timer=LOCKOUT_CYC.
  - The failing key is not re-evaluated as digit 0.
- ENTRY, KEY_VALID=0: hold; MATCH ignored.
- OPEN: UNLOCK=1 for exactly OPEN_CYC cycles, then ENTRY with UNLOCK=0. KEY_VALID ignored.
- LOCKOUT: ALARM=1 for exactly LOCKOUT_CYC cycles, then ENTRY. KEY_VALID ignored. FAIL_CNT reads 0.
- Timer: down-counter, width $clog2(max(OPEN_CYC,LOCKOUT_CYC,TIMEOUT_CYC)+1). The state exits on the cycle the count reaches 1; no wrap.
- Back-to-back keys on consecutive cycles are legal, and each is evaluated.
- Reset mid-OPEN or mid-LOCKOUT drops UNLOCK/ALARM immediately, without waiting for a clock edge.

Optional Feature:
- Macro: COMBO_LOCK_TIMEOUT_EN.
- Defined: in ENTRY with idx>0, TIMEOUT_CYC consecutive cycles without KEY_VALID reset idx to 0. fail_cnt is unchanged. Any KEY_VALID restarts the timeout count.
- Undefined: no timeout logic; partial entry is held indefinitely.

Decomposition:
- Package combo_lock_pkg:
  - State typedef: ENTRY=2'b00, OPEN=2'b01, LOCKOUT=2'b10.
  - DIGIT_W=2.
  - Helper function returning the timer width.
- Sub-module lock_timer: loadable down-counter with load, load value, and done. Shared by OPEN, LOCKOUT and the timeout path.

Test Plan (bench instantiates equality_comparator; EXP drives B; bench drives A; code digits 00,11,01,10):
- Reset: hold rst_n=0 for 3 cycles -> UNLOCK=0, ALARM=0, FAIL_CNT=0, EXP_0/EXP_1=0/0.
- Correct entry: keys 00,11,01,10 on consecutive cycles -> UNLOCK=1 from the cycle after key 4 for 8 cycles, then 0; EXP returns to 00.
- Wrong digit 2: keys 00,10 -> FAIL_CNT=1, EXP=00, UNLOCK stays 0. Then a correct full sequence -> UNLOCK=1 and FAIL_CNT=0.
- Lockout: three single wrong keys (01) -> ALARM=1 for 16 cycles. Correct sequence strobed during lockout -> no UNLOCK, no idx change. After exit, FAIL_CNT=0.
- Async reset: rst_n=0 on cycle 3 of OPEN, between clock edges -> UNLOCK=0 immediately; state ENTRY after release.
- Macro defined: keys 00,11 then 32 idle cycles -> EXP=00, FAIL_CNT=0. Macro undefined: EXP stays 01.
